data_pack: RTL and testbench
============================

// Module: data_pack
// PURPOSE
// - Packs an LSB-first stream of INPUT_SIZE-bit values into DATA_SIZE-bit words with sop/eop framing.
// - Transmit-side counterpart of the 32b->7b unpacker; data_pack -> data_unpack must round-trip bit-exact.
// - Sits between the 7-bit sample source and the 32-bit word link. Valid/ready handshake on both sides.
// PARAMETERS
// - DATA_BITWIDTH  5                 log2 of output word width
// - INPUT_SIZE     7                 input value width; must be < DATA_SIZE
// - DATA_SIZE      2**DATA_BITWIDTH  output word width (derived, do not override)
// PORTS
// - clk        in   1           clock, all state on rising edge
// - rst_n      in   1           asynchronous, active-low reset
// - ready_out  out  1           upstream may transfer this cycle
// - valid_in   in   1           value transfers when valid_in & ready_out
// - data_in    in   INPUT_SIZE  input value
// - sop_in     in   1           first value of packet
// - eop_in     in   1           last value of packet
// - valid_out  out  1           registered; data_out/sop_out/eop_out valid
// - data_out   out  DATA_SIZE   packed word, first value in bits [INPUT_SIZE-1:0]
// - sop_out    out  1           with first word of packet
// - eop_out    out  1           with last word of packet
// - ready_in   in   1           downstream accepts word when valid_out & ready_in
// BEHAVIOUR
// - Reset (rst_n low, async): valid_out/sop_out/eop_out=0, data_out=0, acc=0, count=0, state IDLE.
//   No transfer is taken while rst_n low; reset mid-packet discards all residual bits.
// - State: acc (DATA_SIZE+INPUT_SIZE-1 bits), count (DATA_BITWIDTH+1 bits) = valid bits held in acc.
// - FSM IDLE: ready_out=slot_free. Non-sop values are accepted and dropped. sop_in -> PACK.
// - FSM PACK: ready_out=slot_free. Accepted value: acc |= data_in<<count; count+=INPUT_SIZE.
// - Word complete (new count >= DATA_SIZE): out reg <= acc[DATA_SIZE-1:0]; acc >>= DATA_SIZE; count -= DATA_SIZE.
// - eop accept, new count < DATA_SIZE: emit acc, zero above count, eop_out=1; clear acc/count; -> IDLE.
// - eop accept, new count == DATA_SIZE: emit word with eop_out=1; clear; -> IDLE.
// - eop accept, new count > DATA_SIZE: emit full word, eop_out=0; -> FLUSH.
// - FSM FLUSH: ready_out=0. When slot_free, emit remainder zero-padded, eop_out=1; clear; -> IDLE.
// - slot_free = !valid_out | ready_in. Out reg holds word/flags stable until taken.
// - A value completing a word is accepted only when slot_free.
// - Latency: word on valid_out the cycle after the completing value is accepted.
// - sop_out=1 on first word emitted after sop. A packet of one value (sop&eop) gives one word, sop_out=eop_out=1.
// - sop_in in PACK (missing eop): residual bits discarded; acc restarts with this value as the new packet.
// - Throughput: no dead input cycles while downstream ready, except one FLUSH cycle per eop with remainder.
//   Back-to-back packets: sop accepted the cycle after eop, no gap.
// - Bits never reach data_out from values received outside sop..eop.
// CONFIGURATION
// - DATA_PACK_ERR_EN defined: adds port err_out (out, 1, registered, reset 0).
//   err_out pulses 1 cycle after each accepted value dropped in IDLE, or after sop_in accepted in PACK.
// - DATA_PACK_ERR_EN undefined: no err_out port; the same events are silently handled as above.
// TESTING
// - sop 7'h5A,00,33,00,eop 7'h7F; ready_in=1 -> 32'hF00C_C05A sop_out=1, then FLUSH, 32'h0000_0007 eop_out=1.
// - 32 values 7'h7F (sop first, eop last), ready_in=1 -> 7 words 32'hFFFF_FFFF, eop on 7th, ready_out never low.
// - single value 7'h55 with sop&eop -> one word 32'h0000_0055, sop_out=eop_out=1; next sop accepted next cycle.
// - ready_in=0 for 5 cycles with a word pending -> data_out held; ready_out=0 on completing beat; resumes, no loss.
// - values 7'h11,7'h22 before sop, then sop 7'h01,eop 7'h02 -> one word 32'h0000_0101 (ERR_EN: err_out pulses x2).
// - rst_n low mid-packet (count=20) -> outputs 0 at once; next packet sop 7'h03,eop -> 32'h0000_0003, no residue.

Source files
------------

// File: rtl/data_pack.sv
// -----------------------------------------------------------------------------
// data_pack
//   Packs an LSB-first stream of INPUT_SIZE-bit values into DATA_SIZE-bit words
//   with sop/eop framing. It is the transmit-side partner of the word->value
//   unpacker, so a packet passed through both comes back bit-exact.
//
//   Optional feature (macro DATA_PACK_ERR_EN): adds a registered err_out pulse
//   for each value dropped outside a packet and for each sop that arrives
//   while a packet is still open.
//
// Ports
//   clk        in   clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   ready_out  out  upstream may transfer this cycle
//   valid_in   in   input value offered; transfers on valid_in & ready_out
//   data_in    in   INPUT_SIZE-bit value
//   sop_in     in   first value of a packet
//   eop_in     in   last value of a packet
//   valid_out  out  registered; data_out/sop_out/eop_out are valid
//   data_out   out  packed word, first value in bits [INPUT_SIZE-1:0]
//   sop_out    out  set on the first word of a packet
//   eop_out    out  set on the last word of a packet
//   ready_in   in   downstream takes the word on valid_out & ready_in
//   err_out    out  (DATA_PACK_ERR_EN only) one-cycle framing error pulse
//
// Handshake: on both sides a beat transfers on the rising edge where valid
// and ready are both high. The output register holds word and flags stable
// while valid_out is high and ready_in is low; a new word is only loaded
// when the register is free (empty, or being drained in the same cycle).
// -----------------------------------------------------------------------------
module data_pack #(
  parameter int DATA_BITWIDTH = 5,
  parameter int INPUT_SIZE    = 7,
  parameter int DATA_SIZE     = 2**DATA_BITWIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready_out,
  input  logic                  valid_in,
  input  logic [INPUT_SIZE-1:0] data_in,
  input  logic                  sop_in,
  input  logic                  eop_in,
  output logic                  valid_out,
  output logic [DATA_SIZE-1:0]  data_out,
  output logic                  sop_out,
  output logic                  eop_out,
  input  logic                  ready_in
`ifdef DATA_PACK_ERR_EN
  ,
  output logic                  err_out
`endif
);

  localparam int ACC_W = DATA_SIZE + INPUT_SIZE - 1;
  localparam int CNT_W = DATA_BITWIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 first_q, first_d;      // next emitted word carries sop
  logic                 valid_out_q, valid_out_d;
  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic                 sop_out_q, sop_out_d;
  logic                 eop_out_q, eop_out_d;

  logic                 slot_free;
  logic                 accept;
  logic                 start_pkt;
  logic                 take;
  logic                 first_now;
  logic [ACC_W-1:0]     base_acc;
  logic [CNT_W-1:0]     base_count;
  logic [ACC_W-1:0]     new_acc;
  logic [CNT_W-1:0]     new_count;

  assign slot_free = !valid_out_q || ready_in;

  // ready_out is held low during reset so no transfer is seen upstream.
  always_comb begin
    ready_out = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE, ST_PACK: ready_out = slot_free;
        default:          ready_out = 1'b0;
      endcase
    end
  end

  assign accept    = valid_in && ready_out;
  // A sop always starts a fresh packet; in PACK this drops the residual bits.
  assign start_pkt = accept && sop_in;
  assign take      = accept && (sop_in || (state_q == ST_PACK));
  assign first_now = start_pkt || first_q;

  always_comb begin
    base_acc   = start_pkt ? '0 : acc_q;
    base_count = start_pkt ? '0 : count_q;
    new_acc    = base_acc |
                 ({{(ACC_W-INPUT_SIZE){1'b0}}, data_in} << base_count);
    new_count  = base_count + CNT_W'(INPUT_SIZE);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    first_d     = first_q;
    valid_out_d = valid_out_q && !ready_in;
    data_out_d  = data_out_q;
    sop_out_d   = sop_out_q;
    eop_out_d   = eop_out_q;

    case (state_q)
      ST_IDLE, ST_PACK: begin
        if (take) begin
          if (eop_in && (new_count <= CNT_W'(DATA_SIZE))) begin
            // Whole tail fits in one word; bits above count are already zero.
            valid_out_d = 1'b1;
            data_out_d  = new_acc[DATA_SIZE-1:0];
            sop_out_d   = first_now;
            eop_out_d   = 1'b1;
            acc_d       = '0;
            count_d     = '0;
            first_d     = 1'b0;
            state_d     = ST_IDLE;
          end else if (new_count >= CNT_W'(DATA_SIZE)) begin
            // Full word out; with eop the leftover bits need a FLUSH beat.
            valid_out_d = 1'b1;
            data_out_d  = new_acc[DATA_SIZE-1:0];
            sop_out_d   = first_now;
            eop_out_d   = 1'b0;
            acc_d       = new_acc >> DATA_SIZE;
            count_d     = new_count - CNT_W'(DATA_SIZE);
            first_d     = 1'b0;
            state_d     = eop_in ? ST_FLUSH : ST_PACK;
          end else begin
            acc_d   = new_acc;
            count_d = new_count;
            first_d = first_now;
            state_d = ST_PACK;
          end
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          valid_out_d = 1'b1;
          data_out_d  = acc_q[DATA_SIZE-1:0];
          sop_out_d   = first_q;
          eop_out_d   = 1'b1;
          acc_d       = '0;
          count_d     = '0;
          first_d     = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        count_d = '0;
        first_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      first_q     <= 1'b0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      sop_out_q   <= 1'b0;
      eop_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      first_q     <= first_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      sop_out_q   <= sop_out_d;
      eop_out_q   <= eop_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign sop_out   = sop_out_q;
  assign eop_out   = eop_out_q;

`ifdef DATA_PACK_ERR_EN
  logic err_d, err_q;

  // Framing errors: a value dropped outside a packet, or a sop cutting off
  // an open packet.
  always_comb begin
    err_d = accept && (((state_q == ST_IDLE) && !sop_in) ||
                       ((state_q == ST_PACK) && sop_in));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`endif

endmodule

// File: tb/tb_data_pack.sv
module tb_data_pack;

  logic        clk;
  logic        rst_n;
  logic        ready_out;
  logic        valid_in;
  logic [6:0]  data_in;
  logic        sop_in;
  logic        eop_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic        sop_out;
  logic        eop_out;
  logic        ready_in;
`ifdef DATA_PACK_ERR_EN
  logic        err_out;
  int          err_cnt = 0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected words: {sop, eop, data}
  logic [33:0] exp_q[$];

  typedef struct {
    logic       v;
    logic       sop;
    logic       eop;
    logic [6:0] d;
    logic       rdy;
    logic       exp_rdy;
  } vec_t;

  vec_t vecs[$];

  data_pack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready_out (ready_out),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .sop_in    (sop_in),
    .eop_in    (eop_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .ready_in  (ready_in)
`ifdef DATA_PACK_ERR_EN
    ,
    .err_out   (err_out)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic sop, input logic eop,
                              input logic [6:0] d, input logic rdy, input logic exp_rdy);
    vec_t t;
    t.v = v; t.sop = sop; t.eop = eop; t.d = d; t.rdy = rdy; t.exp_rdy = exp_rdy;
    vecs.push_back(t);
  endfunction

  function automatic void exp_word(input logic sop, input logic eop, input logic [31:0] w);
    exp_q.push_back({sop, eop, w});
  endfunction

  // Offer one value and wait (bounded) for it to be accepted.
  task automatic send(input logic [6:0] d, input logic sop, input logic eop);
    bit got;
    got = 0;
    valid_in = 1'b1; data_in = d; sop_in = sop; eop_in = eop;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready_out) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got ready_out=0 for 50 cycles expected 1");
    end
    @(posedge clk); #1;
    valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL word_unexpected: got %0h expected none", {sop_out, eop_out, data_out});
        end else begin
          chk("word", {30'd0, sop_out, eop_out, data_out}, {30'd0, exp_q.pop_front()});
        end
      end
`ifdef DATA_PACK_ERR_EN
      if (err_out) err_cnt++;
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; sop_in = 1'b0; eop_in = 1'b0; ready_in = 1'b1;

    // Table: single-value packet, then a sop on the very next cycle.
    add(1, 1, 1, 7'h55, 1, 1);  exp_word(1, 1, 32'h0000_0055);
    // 35-bit packet: one full word, one FLUSH beat with the 3-bit remainder.
    add(1, 1, 0, 7'h5A, 1, 1);
    add(1, 0, 0, 7'h00, 1, 1);
    add(1, 0, 0, 7'h33, 1, 1);
    add(1, 0, 0, 7'h00, 1, 1);
    add(1, 0, 1, 7'h7F, 1, 1);  exp_word(1, 0, 32'hF00C_C05A);
    add(0, 0, 0, 7'h00, 1, 0);  exp_word(0, 1, 32'h0000_0007);
    // 32 x 7'h7F = exactly 7 words, ready_out never drops.
    for (int i = 0; i < 32; i++) add(1, i == 0, i == 31, 7'h7F, 1, 1);
    for (int i = 0; i < 7; i++) exp_word(i == 0, i == 6, 32'hFFFF_FFFF);
    // Values outside a packet are dropped.
    add(1, 0, 0, 7'h11, 1, 1);
    add(1, 0, 0, 7'h22, 1, 1);
    add(1, 1, 0, 7'h01, 1, 1);
    add(1, 0, 1, 7'h02, 1, 1);  exp_word(1, 1, 32'h0000_0101);
    // sop while a packet is open restarts it.
    add(1, 1, 0, 7'h11, 1, 1);
    add(1, 1, 0, 7'h22, 1, 1);
    add(1, 0, 1, 7'h33, 1, 1);  exp_word(1, 1, 32'h0000_19A2);
    add(0, 0, 0, 7'h00, 1, 1);
    add(0, 0, 0, 7'h00, 1, 1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_sop_eop", {sop_out, eop_out}, 0);
    chk("rst_ready_out", ready_out, 0);
`ifdef DATA_PACK_ERR_EN
    chk("rst_err_out", err_out, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Apply the table
    for (int i = 0; i < vecs.size(); i++) begin
      valid_in = vecs[i].v; sop_in = vecs[i].sop; eop_in = vecs[i].eop;
      data_in  = vecs[i].d; ready_in = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("ready_out[%0d]", i), ready_out, vecs[i].exp_rdy);
      @(posedge clk); #1;
    end

    // Backpressure: word pending while ready_in low, then resume without loss.
    ready_in = 1'b0;
    send(7'h7F, 1, 0);
    repeat (3) send(7'h7F, 0, 0);
    send(7'h7F, 0, 0);
    exp_word(1, 0, 32'hFFFF_FFFF);
    valid_in = 1'b1; data_in = 7'h7F; sop_in = 1'b0; eop_in = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", valid_out, 1);
      chk("hold_data", data_out, 32'hFFFF_FFFF);
      chk("hold_ready_out", ready_out, 0);
    end
    @(posedge clk); #1;
    ready_in = 1'b1;
    send(7'h7F, 0, 0);
    exp_word(0, 1, 32'h0001_FFFF);
    send(7'h7F, 0, 1);
    idle(3);

    // Reset mid-packet with 20 bits held.
    exp_word(1, 0, 32'hFFFF_FFFF);
    exp_word(0, 0, 32'hFFFF_FFFF);
    send(7'h7F, 1, 0);
    repeat (11) send(7'h7F, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_sop_eop", {sop_out, eop_out}, 0);
    chk("midrst_ready_out", ready_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_word(1, 1, 32'h0000_0003);
    send(7'h03, 1, 1);
    idle(3);

    chk("exp_q_empty", exp_q.size(), 0);
`ifdef DATA_PACK_ERR_EN
    chk("err_pulses", err_cnt, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
